// File: rtl/srt4_iter_unit_if.sv
// Port bundle of the radix-4 SRT iteration unit: request/result signals plus the
// partial-remainder register handshake (w_next/w_load out, w_q back in).
interface srt4_iter_unit_if #(
    parameter int WIDTH = 24,
    parameter int ITER  = 13
);
    logic                  start;
    logic [WIDTH-1:0]      dividend;
    logic [WIDTH-1:0]      divisor;
    logic [WIDTH+1:0]      w_q;
    logic [WIDTH+1:0]      w_next;
    logic                  w_load;
    logic                  busy;
    logic                  done;
    logic [2*ITER-1:0]     quotient;
    logic [WIDTH+1:0]      remainder;

    modport master (
        output start, dividend, divisor, w_q,
        input  w_next, w_load, busy, done, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor, w_q,
        output w_next, w_load, busy, done, quotient, remainder
    );
endinterface

// File: rtl/srt4_iter_unit.sv
// Radix-4 SRT mantissa divider iteration unit: digit selection in {-2..2},
// on-the-fly quotient conversion and final sign correction of the remainder.
module srt4_iter_unit #(
    parameter int WIDTH = 24,
    parameter int ITER  = 13
) (
    input logic             clk,
    input logic             reset,
    srt4_iter_unit_if.slave bus
);
    localparam int RW = WIDTH + 2;
    localparam int QW = 2 * ITER;
    localparam int PW = RW + 4;
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_CORR} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     d_reg;
    logic [QW-1:0]        q_reg, qm_reg, q_nxt, qm_nxt;
    logic [CW-1:0]        cnt;
    logic signed [PW-1:0] p, d_one, d_half, d_3half, sub;

    // Everything is in remainder units (2^-25): d = 4*D, so d/2 and 3d/2 stay exact integers.
    assign p       = {{(PW-RW-2){bus.w_q[RW-1]}}, bus.w_q, 2'b00};
    assign d_one   = {{(PW-WIDTH-2){1'b0}}, d_reg, 2'b00};
    assign d_half  = d_one >>> 1;
    assign d_3half = d_one + d_half;

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        sub    = '0;
        q_nxt  = {q_reg[QW-3:0], 2'd0};
        qm_nxt = {qm_reg[QW-3:0], 2'd3};
        if (p >= d_3half) begin
            sub    = d_one <<< 1;
            q_nxt  = {q_reg[QW-3:0], 2'd2};
            qm_nxt = {q_reg[QW-3:0], 2'd1};
        end else if (p >= d_half) begin
            sub    = d_one;
            q_nxt  = {q_reg[QW-3:0], 2'd1};
            qm_nxt = {q_reg[QW-3:0], 2'd0};
        end else if (p >= -d_half) begin
            sub    = '0;
        end else if (p >= -d_3half) begin
            sub    = -d_one;
            q_nxt  = {qm_reg[QW-3:0], 2'd3};
            qm_nxt = {qm_reg[QW-3:0], 2'd2};
        end else begin
            sub    = -(d_one <<< 1);
            q_nxt  = {qm_reg[QW-3:0], 2'd2};
            qm_nxt = {qm_reg[QW-3:0], 2'd1};
        end
    end

    always_comb begin
        state_nxt  = state;
        bus.w_next = RW'(p - sub);
        unique case (state)
            S_IDLE: begin
                bus.w_next = {2'b00, bus.dividend};
                if (bus.start) state_nxt = S_ITER;
            end
            S_ITER:  if (cnt == CW'(ITER - 1)) state_nxt = S_CORR;
            S_CORR:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Gated by reset so an aborting reset silences the register load immediately.
    assign bus.busy   = (state != S_IDLE) && !reset;
    assign bus.w_load = ((state == S_IDLE && bus.start) || state == S_ITER) && !reset;

    // NOTE: state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            d_reg         <= '0;
            q_reg         <= '0;
            qm_reg        <= '0;
            cnt           <= '0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.done      <= 1'b0;
        end else begin
            state    <= state_nxt;
            bus.done <= (state == S_CORR);
            case (state)
                S_IDLE: if (bus.start) begin
                    d_reg  <= bus.divisor;
                    q_reg  <= '0;
                    qm_reg <= '0;
                    cnt    <= '0;
                end
                S_ITER: begin
                    q_reg  <= q_nxt;
                    qm_reg <= qm_nxt;
                    cnt    <= cnt + CW'(1);
                end
                S_CORR: begin
                    // Negative final remainder: step back one quotient unit and add d.
                    if (bus.w_q[RW-1]) begin
                        bus.quotient  <= qm_reg;
                        bus.remainder <= bus.w_q + {d_reg, 2'b00};
                    end else begin
                        bus.quotient  <= q_reg;
                        bus.remainder <= bus.w_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_srt4_iter_unit.sv
// Bench for srt4_iter_unit: models the remainder register, checks directed vectors,
// random pairs against exact integer division, mid-run reset and back-to-back starts.
module tb_srt4_iter_unit;
    logic clk = 1'b0;
    logic reset;

    srt4_iter_unit_if bus();
    srt4_iter_unit dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] x;
        logic [23:0] d;
        logic [25:0] q;
        logic [25:0] r;
    } vec_t;

    // Partial-remainder register the unit sits in front of.
    logic [25:0] w_reg = '0;
    assign bus.w_q = w_reg;
    always @(posedge clk) if (bus.w_load === 1'b1) w_reg <= bus.w_next;

    task automatic check_true(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check(input string name, input longint act, input longint req);
        check_true(name, act == req, act, req);
    endtask

    // Remainder bound |w| <= d/2 (2*D in remainder units) on every load.
    logic [23:0] mon_d = 24'h800000;
    always @(posedge clk) begin
        if (bus.w_load === 1'b1) begin
            longint wv, lim;
            wv  = longint'($signed(bus.w_next));
            if (wv < 0) wv = -wv;
            lim = 2 * longint'(mon_d);
            check_true("w_bound", wv <= lim, wv, lim);
        end
    end

    // Q = floor(X*2^24 / D), R = X*2^26 - 4*D*Q.
    function automatic void model(input logic [23:0] x, input logic [23:0] d,
                                  output logic [25:0] q, output logic [25:0] r);
        longint qq;
        qq = (longint'(x) << 24) / longint'(d);
        q  = 26'(qq);
        r  = 26'((longint'(x) << 26) - 4 * longint'(d) * qq);
    endfunction

    // Called right after a falling edge; returns at the falling edge where done is seen.
    task automatic run_div(input logic [23:0] x, input logic [23:0] d, output int lat);
        bus.start    = 1'b1;
        bus.dividend = x;
        bus.divisor  = d;
        mon_d        = d;
        #1;
        check("start_wload", longint'(bus.w_load), 1);
        check("start_wnext", longint'(bus.w_next), longint'({2'b00, x}));
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            bus.start = 1'b0;
            if (bus.done === 1'b1) break;
        end
    endtask

    task automatic check_result(input string tag, input logic [23:0] x, input logic [23:0] d);
        logic [25:0] eq, er;
        model(x, d, eq, er);
        check({tag, "_quotient"}, longint'(bus.quotient), longint'(eq));
        check({tag, "_remainder"}, longint'(bus.remainder), longint'(er));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   lat;
        logic [23:0] x, d;

        vecs[0] = '{x: 24'h800000, d: 24'h800000, q: 26'h1000000, r: 26'h0000000};
        vecs[1] = '{x: 24'hC00000, d: 24'h800000, q: 26'h1800000, r: 26'h0000000};
        vecs[2] = '{x: 24'h800000, d: 24'hC00000, q: 26'h0AAAAAA, r: 26'h2000000};
        vecs[3] = '{x: 24'hFFFFFF, d: 24'h800000, q: 26'h1FFFFFE, r: 26'h0000000};
        vecs[4] = '{x: 24'h800000, d: 24'hFFFFFF, q: 26'h0800000, r: 26'h2000000};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_done", longint'(bus.done), 0);
        check("rst_wload", longint'(bus.w_load), 0);
        check("rst_quotient", longint'(bus.quotient), 0);
        check("rst_remainder", longint'(bus.remainder), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_div(vecs[i].x, vecs[i].d, lat);
            check("vec_latency", longint'(lat), 15);
            check("vec_quotient", longint'(bus.quotient), longint'(vecs[i].q));
            check("vec_remainder", longint'(bus.remainder), longint'(vecs[i].r));
            check("vec_busy_on_done", longint'(bus.busy), 0);
            @(negedge clk);
            check("vec_done_pulse", longint'(bus.done), 0);
            check("vec_idle_wload", longint'(bus.w_load), 0);
        end

        // Random pairs, issued back to back on each done cycle.
        for (int i = 0; i < 1000; i++) begin
            x = {1'b1, 23'($urandom)};
            d = {1'b1, 23'($urandom)};
            run_div(x, d, lat);
            check("rnd_latency", longint'(lat), 15);
            check_result("rnd", x, d);
        end

        // Reset in the 6th ITER cycle aborts; a fresh division follows.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 24'hABCDEF;
        bus.divisor  = 24'h912345;
        mon_d        = 24'h912345;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy_now", longint'(bus.busy), 0);
        check("abort_wload_now", longint'(bus.w_load), 0);
        @(negedge clk);
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_done", longint'(bus.done), 0);
        check("abort_wload", longint'(bus.w_load), 0);
        check("abort_quotient", longint'(bus.quotient), 0);
        check("abort_remainder", longint'(bus.remainder), 0);
        reset = 1'b0;
        run_div(24'hC00000, 24'h800000, lat);
        check("post_abort_latency", longint'(lat), 15);
        check_result("post_abort", 24'hC00000, 24'h800000);

        // start held high for the whole run with inputs changing mid-flight.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 24'h800000;
        bus.divisor  = 24'hC00000;
        mon_d        = 24'hC00000;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done === 1'b1) break;
            if (lat == 3) begin
                bus.dividend = 24'hFFFFFF;
                bus.divisor  = 24'h800001;
            end
        end
        check("held_latency", longint'(lat), 15);
        check("held_quotient", longint'(bus.quotient), 26'h0AAAAAA);
        check("held_remainder", longint'(bus.remainder), 26'h2000000);
        run_div(24'hC00000, 24'h800000, lat);
        check("chain_latency", longint'(lat), 15);
        check("chain_quotient", longint'(bus.quotient), 26'h1800000);
        check("chain_remainder", longint'(bus.remainder), 26'h0000000);
        @(negedge clk);
        check("chain_done_pulse", longint'(bus.done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
